sample_frame_packer: RTL and testbench

Upstream neighbour of the FT2232H synchronous-FIFO transmitter. Collects SAMPLES consecutive DATA_WIDTH-bit ADC samples into one wide frame, then presents that frame on a stable bus with an enable for the TX stage. It is double-buffered: a fill buffer accumulates the next frame while the output buffer is held for the TX stage. The block also tracks samples dropped on overrun.

---
 rtl/sample_frame_packer.sv | 109 ++++++++++
 tb/tb_sample_frame_packer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sample_frame_packer.sv
// rtl/sample_frame_packer.sv - double-buffered sample-to-frame packer for the FT2232H TX stage
module sample_frame_packer #(
  parameter int DATA_WIDTH = 14,
  parameter int SAMPLES    = 40,
  parameter int DROP_CNT_W = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH-1:0]             sample_in,
  input  logic                              sample_valid,
  output logic                              sample_ready,
  input  logic                              frame_release,
  output logic [0:DATA_WIDTH*SAMPLES-1]     frame_out,
  output logic                              frame_enable,
  output logic                              frame_start,
  output logic                              overflow,
  output logic [DROP_CNT_W-1:0]             drop_count,
  input  logic                              stat_clr
);

  localparam int FRAME_W = DATA_WIDTH * SAMPLES;
  localparam int IDX_W   = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES - 1);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HELD  = 1'b1;

  logic [0:0]            buf_state;
  logic [IDX_W-1:0]      fill_idx;
  logic                  pending;
  logic [0:FRAME_W-1]    fill_buf;
  logic [0:FRAME_W-1]    frame_next;

  logic accept;
  logic drop;
  logic complete;
  logic load;
  logic held;

  assign held         = (buf_state == ST_HELD);
  assign frame_enable = held;
  assign sample_ready = ~pending;
  assign accept       = sample_valid & ~pending;
  assign drop         = sample_valid & pending;
  assign complete     = accept & (fill_idx == IDX_LAST);
  // A frame leaves the fill buffer either straight off its last sample or
  // later from the pending state; both need the TX side free or releasing.
  assign load         = (complete & (~held | frame_release)) | (pending & frame_release);

  // Fill buffer with the current sample merged in, so the completing sample
  // reaches frame_out on the same edge it is accepted.
  always_comb begin
    frame_next = fill_buf;
    if (accept) begin
      for (int s = 0; s < SAMPLES; s++) begin
        if (fill_idx == IDX_W'(s)) begin
          frame_next[s*DATA_WIDTH +: DATA_WIDTH] = sample_in;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_buf <= '0;
      fill_idx <= '0;
    end else if (accept) begin
      fill_buf <= frame_next;
      fill_idx <= complete ? '0 : fill_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_state   <= ST_EMPTY;
      pending     <= 1'b0;
      frame_out   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= load;
      if (load) begin
        frame_out <= frame_next;
        buf_state <= ST_HELD;
        pending   <= 1'b0;
      end else if (complete) begin
        pending   <= 1'b1;
      end else if (frame_release && held) begin
        buf_state <= ST_EMPTY;
      end
    end
  end

  // A clear coincident with a drop still records that drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (stat_clr) begin
      overflow   <= drop;
      drop_count <= drop ? DROP_CNT_W'(1) : '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != {DROP_CNT_W{1'b1}}) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_frame_packer.sv
// tb/tb_sample_frame_packer.sv - randomized check of sample_frame_packer against a queue-based model
module tb_sample_frame_packer;

  localparam int DW = 14;
  localparam int NS = 40;
  localparam int CW = 16;
  localparam int FW = DW * NS;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          sample_ready;
  logic          frame_release;
  logic [0:FW-1] frame_out;
  logic          frame_enable;
  logic          frame_start;
  logic          overflow;
  logic [CW-1:0] drop_count;
  logic          stat_clr;

  sample_frame_packer #(.DATA_WIDTH(DW), .SAMPLES(NS), .DROP_CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_release(frame_release),
    .frame_out    (frame_out),
    .frame_enable (frame_enable),
    .frame_start  (frame_start),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .stat_clr     (stat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: samples of the frame being collected, the frame held
  // for TX, and whether a finished frame is waiting behind it.
  int            fillq[$];
  logic [0:FW-1] m_out;
  bit            m_held;
  bit            m_pend;
  bit            m_start;
  bit            m_ovf;
  int            m_drops;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample 0 first; within a slot the sample MSB takes the lowest index.
  function automatic logic [0:FW-1] pack_frame();
    logic [0:FW-1] f;
    f = '0;
    for (int k = 0; k < NS; k++)
      for (int b = 0; b < DW; b++)
        f[k*DW + b] = fillq[k][DW-1-b];
    return f;
  endfunction

  task automatic model_reset();
    fillq.delete();
    m_out = '0; m_held = 0; m_pend = 0; m_start = 0; m_ovf = 0; m_drops = 0;
  endtask

  task automatic model_step();
    bit dropped;
    dropped = sample_valid && m_pend;
    if (sample_valid && !m_pend) fillq.push_back(int'(sample_in));
    m_start = 0;
    if (fillq.size() == NS && (!m_held || frame_release)) begin
      m_out = pack_frame();
      m_held = 1; m_start = 1; m_pend = 0;
      fillq.delete();
    end else if (fillq.size() == NS) begin
      m_pend = 1;
    end else if (frame_release && m_held) begin
      m_held = 0;
    end
    if (stat_clr) begin
      m_drops = dropped ? 1 : 0;
      m_ovf = dropped;
    end else if (dropped) begin
      m_ovf = 1;
      if (m_drops < (1 << CW) - 1) m_drops++;
    end
  endtask

  task automatic check_all();
    chk("frame_enable", FW'(frame_enable), FW'(m_held));
    chk("frame_start",  FW'(frame_start),  FW'(m_start));
    chk("sample_ready", FW'(sample_ready), FW'(!m_pend));
    chk("overflow",     FW'(overflow),     FW'(m_ovf));
    chk("drop_count",   FW'(drop_count),   FW'(m_drops));
    chk("frame_out",    frame_out,         m_out);
  endtask

  task automatic put(input bit v, input logic [DW-1:0] d, input bit rel, input bit clr);
    sample_valid = v; sample_in = d; frame_release = rel; stat_clr = clr;
    model_step();
    @(posedge clk);
    @(negedge clk);
    sample_valid = 0; sample_in = '0; frame_release = 0; stat_clr = 0;
    check_all();
  endtask

  initial begin
    logic [0:FW-1] fo;
    rst_n = 0; sample_in = '0; sample_valid = 0; frame_release = 0; stat_clr = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1;

    // Counting frame 1..40 into an empty output buffer
    for (int i = 1; i <= NS; i++) put(1, DW'(i), 0, 0);
    fo = frame_out;
    chk("first_start", FW'(frame_start), FW'(1));
    chk("slot0", FW'(fo[0:13]), FW'(14'h0001));
    chk("slot39", FW'(fo[546:559]), FW'(14'h0028));
    put(0, '0, 0, 0);

    // Second frame behind a held one, then drops, then release
    for (int i = 0; i < NS; i++) put(1, DW'($urandom), 0, 0);
    chk("pend_ready", FW'(sample_ready), FW'(0));
    for (int i = 0; i < 3; i++) put(1, DW'($urandom), 0, 0);
    chk("drops3", FW'(drop_count), FW'(3));
    put(0, '0, 1, 0);
    chk("rel_start", FW'(frame_start), FW'(1));
    chk("rel_ready", FW'(sample_ready), FW'(1));

    // Release coincident with the last sample: no pending, no drops
    for (int i = 0; i < NS - 1; i++) put(1, DW'($urandom), 0, 0);
    put(1, DW'($urandom), 1, 0);
    chk("coinc_start", FW'(frame_start), FW'(1));
    chk("coinc_ready", FW'(sample_ready), FW'(1));
    chk("coinc_drops", FW'(drop_count), FW'(3));

    // Asynchronous reset mid-frame with a held frame
    for (int i = 0; i < 17; i++) put(1, DW'($urandom), 0, 0);
    #2 rst_n = 0;
    #1 model_reset();
    check_all();
    chk("arst_enable", FW'(frame_enable), FW'(0));
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < NS; i++) put(1, DW'($urandom), 0, 0);

    // Release empties the buffer; a second release is ignored
    put(0, '0, 1, 0);
    put(0, '0, 1, 0);
    chk("idle_rel_start", FW'(frame_start), FW'(0));
    chk("idle_rel_enable", FW'(frame_enable), FW'(0));

    // Random traffic
    for (int i = 0; i < 600; i++)
      put($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 19) == 0,
          $urandom_range(0, 39) == 0);

    // Saturate the drop counter, then clear coincident with a drop
    for (int i = 0; i < 200 && !m_pend; i++) put(1, DW'($urandom), 0, 0);
    chk("sat_pending", FW'(sample_ready), FW'(0));
    for (int i = 0; i < 70000; i++) put(1, DW'($urandom), 0, 0);
    chk("sat_count", FW'(drop_count), FW'(16'hFFFF));
    put(1, DW'($urandom), 0, 1);
    chk("clr_drop_count", FW'(drop_count), FW'(1));
    chk("clr_drop_ovf", FW'(overflow), FW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
